ntt_ctrl: RTL
=============

# ntt_ctrl

Sequencer for the Kyber butterfly datapath. Walks a 256-coefficient polynomial through the 7 forward-NTT or 7 inverse-NTT layers. Per butterfly it issues a pair of read addresses, a twiddle ROM index and the butterfly mode. It then issues the matching write-back addresses once the result emerges from the memory and butterfly pipeline. The block sits between the top-level command interface and the coefficient RAM, twiddle ROM and butterfly core.

## Interface
Parameters:
- `RD_LAT`, default 1: read latency of the coefficient RAM and twiddle ROM.
- `BF_LAT`, default 5: butterfly latency in NTT and INTT modes.
- `WB_LAT`, default `RD_LAT+BF_LAT`: distance from read issue to write issue.

Ports:
- `clk` in 1: single clock; everything on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request; ignored unless idle.
- `inv` in 1: 0 = NTT, 1 = INTT; sampled with `start`.
- `busy` out 1: transform in progress.
- `done` out 1: one-cycle completion pulse.
- `bf_mode` out 2: butterfly mode; NTT=0, INTT=1.
- `rd_en` out 1: read pair valid.
- `rd_addr_a` out 8: low index `j`.
- `rd_addr_b` out 8: high index `j+len`.
- `zeta_idx` out 7: twiddle ROM index, aligned with `rd_en`.
- `wr_en` out 1: write-back pair valid.
- `wr_addr_a` out 8: write address for butterfly `out_1`.
- `wr_addr_b` out 8: write address for butterfly `out_2`.

## Operation
- States:
  - IDLE: `start` → RUN. Latch `inv` into `bf_mode`. Clear the layer counter `l` (0..6) and the butterfly counter `b` (0..127).
  - RUN: `rd_en`=1 every cycle and `b` increments. At `b`=127 go to DRAIN.
  - DRAIN: runs for exactly `WB_LAT` cycles, counted down by a small counter. At expiry: if `l`<6, increment `l`, clear `b` and go to RUN; otherwise go to DONE.
  - DONE: lasts 1 cycle with `done`=1, then IDLE.
- Address generation (`lenlog` = log2(len)):
  - `grp` = `b >> lenlog`; `off` = `b & (len-1)`.
  - `rd_addr_a` = `(grp << (lenlog+1)) | off`; `rd_addr_b` = `rd_addr_a + len`.
  - Values fit in 8 bits with no wrap.
- NTT: `lenlog` = 7−`l` (len 128→2); `zeta_idx` = `(1<<l) + grp`.
- INTT: `lenlog` = `l`+1 (len 2→128); `zeta_idx` = `(128>>l) − 1 − grp`.
- Write-back: `{rd_en, rd_addr_a, rd_addr_b}` passes through a `WB_LAT`-deep delay line and appears as `{wr_en, wr_addr_a, wr_addr_b}`.
  - The delay line shifts in every cycle, including DRAIN, where it shifts in zeros.
- Layer hazard: DRAIN guarantees that the first read of layer `l+1` comes strictly after the last write of layer `l`.
  - Read and write to the same address never occur in the same cycle.
- `bf_mode` stays constant from `start` until `done`.
- `start` during any state other than IDLE is ignored; the transform is not restarted.
- Out of scope: final n⁻¹ scaling after INTT, and point-wise multiply scheduling.

## Timing
- Cycle numbering: `start` sampled at the end of cycle 0.
  - First `rd_en` in cycle 1.
  - Layer `L` reads occupy cycles 1+134L .. 128+134L.
  - Last write is in cycle 938; `done` is high in cycle 939.
- `busy` is high in cycles 1..938 (states RUN and DRAIN) and low in DONE.
- Each layer: 128 read cycles plus 6 drain cycles; 896 butterflies in total.
- Reset (asserted asynchronously, at any time including mid-transform):
  - Immediately: state IDLE, all counters 0, delay line cleared.
  - All outputs 0 (`bf_mode`=0, `busy`=0, `done`=0, `rd_en`=0, `wr_en`=0, addresses and `zeta_idx` 0).
  - After reset release, the block waits for a new `start`.

## Structure
- Shared package `kyber_pkg` holds:
  - constants N=256, Q=3329, `BF_LAT`=5;
  - mode codes NTT=0, INTT=1, MULT=2, ADDSUB=3.
- Sub-module `delay_line`: parameterized width and depth shift register with asynchronous active-low clear. It implements the write-back pipeline.
- The FSM, counters and address/zeta arithmetic stay in `ntt_ctrl`.

## Test plan
- NTT start:
  - cycle 1 → rd (0,128), zeta 1;
  - cycle 128 → rd (127,255);
  - cycle 135 → rd (0,64), zeta 2;
  - cycle 199 (b=64) → rd (128,192), zeta 3.
- INTT start:
  - cycle 1 → rd (0,2), zeta 127;
  - cycle 2 → rd (1,3), zeta 127;
  - cycle 3 → rd (4,6), zeta 126;
  - last layer → rd (127,255), zeta 1.
- Write-back: `wr_en`/`wr_addr_*` equal the read stream delayed exactly 6 cycles, with 896 writes in total.
  - A scoreboard flags any read of an address that still has a write pending.
- Completion: `done` pulses only in cycle 939 with `busy`=0.
  - `start` pulsed at cycle 400 has no effect: the addresses are unchanged and `done` is not moved.
- Reset: `rst` low in cycle 300 → all outputs 0 in that cycle.
  - After release, `start` runs a complete 939-cycle transform from a clean pipeline.
- System: `ntt_ctrl` + `butterfly_core` + RAM/ROM models, random polynomial.
  - NTT and INTT results match the golden software model of the same layer schedule bit-exactly.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared Kyber constants, butterfly mode codes and the NTT sequencer types.
package kyber_pkg;

    localparam int N      = 256;
    localparam int Q      = 3329;
    localparam int BF_LAT = 5;
    localparam int LAYERS = 7;
    localparam int NBF    = N / 2;

    typedef enum logic [1:0] {
        MODE_NTT    = 2'd0,
        MODE_INTT   = 2'd1,
        MODE_MULT   = 2'd2,
        MODE_ADDSUB = 2'd3
    } bf_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } ctrl_state_e;

    typedef struct packed {
        logic       en;
        logic [7:0] a;
        logic [7:0] b;
    } addr_pair_t;

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register with asynchronous active-low clear; carries the
// read stream forward to the write-back port.
module delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [DEPTH-1:0][W-1:0] pipe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_ctrl.sv
// Kyber NTT/INTT layer sequencer: read/zeta issue per butterfly, write-back
// addresses replayed WB_LAT cycles later through a delay line.
module ntt_ctrl #(
    parameter int RD_LAT = 1,
    parameter int BF_LAT = kyber_pkg::BF_LAT,
    parameter int WB_LAT = RD_LAT + BF_LAT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       inv,
    output logic       busy,
    output logic       done,
    output logic [1:0] bf_mode,
    output logic       rd_en,
    output logic [7:0] rd_addr_a,
    output logic [7:0] rd_addr_b,
    output logic [6:0] zeta_idx,
    output logic       wr_en,
    output logic [7:0] wr_addr_a,
    output logic [7:0] wr_addr_b
);
    import kyber_pkg::*;

    localparam int       CW     = $clog2(WB_LAT + 1);
    localparam logic [2:0] LAST_L = 3'(LAYERS - 1);
    localparam logic [6:0] LAST_B = 7'(NBF - 1);

    ctrl_state_e   state_q, state_d;
    bf_mode_e      mode_q, mode_d;
    logic [2:0]    l_q, l_d;
    logic [6:0]    b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_NTT;
            l_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            l_q     <= l_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        l_d     = l_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    mode_d  = inv ? MODE_INTT : MODE_NTT;
                    l_d     = '0;
                    b_d     = '0;
                end
            end
            ST_RUN: begin
                b_d = b_q + 7'd1;
                if (b_q == LAST_B) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CW'(WB_LAT - 1);
                end
            end
            ST_DRAIN: begin
                // Hold off the next layer until its last write has landed.
                if (cnt_q == '0) begin
                    if (l_q < LAST_L) begin
                        l_d     = l_q + 3'd1;
                        b_d     = '0;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    logic       run;
    logic [2:0] lenlog;
    logic [6:0] grp, off, zeta;
    logic [7:0] addr_a, addr_b;

    always_comb begin
        run    = (state_q == ST_RUN);
        lenlog = (mode_q == MODE_INTT) ? (l_q + 3'd1) : (3'd7 - l_q);
        grp    = b_q >> lenlog;
        off    = b_q & ((7'd1 << lenlog) - 7'd1);
        addr_a = ({1'b0, grp} << ({1'b0, lenlog} + 4'd1)) | {1'b0, off};
        addr_b = addr_a + (8'd1 << lenlog);
        // 127 >> l equals (128 >> l) - 1, so the INTT index stays in 7 bits.
        zeta   = (mode_q == MODE_INTT) ? ((7'd127 >> l_q) - grp)
                                       : ((7'd1 << l_q) + grp);
    end

    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign bf_mode   = mode_q;
    assign rd_en     = run;
    assign rd_addr_a = run ? addr_a : 8'd0;
    assign rd_addr_b = run ? addr_b : 8'd0;
    assign zeta_idx  = run ? zeta : 7'd0;

    addr_pair_t rd_pair, wr_pair;

    assign rd_pair = '{en: run, a: rd_addr_a, b: rd_addr_b};

    delay_line #(
        .W    ($bits(addr_pair_t)),
        .DEPTH(WB_LAT)
    ) u_wb_dly (
        .clk  (clk),
        .rst_n(rst),
        .d_i  (rd_pair),
        .q_o  (wr_pair)
    );

    assign wr_en     = wr_pair.en;
    assign wr_addr_a = wr_pair.a;
    assign wr_addr_b = wr_pair.b;

endmodule
